// File: rtl/adc_osr_decimator.sv
// adc_osr_decimator: sums 4^k SAR results per window and returns a left-aligned average through a valid/ready register
module adc_osr_decimator #(
   parameter int INPUT_BITS  = 12,
   parameter int OUTPUT_BITS = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [INPUT_BITS-1:0]  data_in,
   input  logic                   data_valid_in,
   input  logic [2:0]             osr_mode_in,
   input  logic                   clear_in,
   input  logic                   result_ready_in,
   output logic [OUTPUT_BITS-1:0] result_out,
   output logic                   result_valid_out,
   output logic                   overrun_out,
   output logic                   busy_out
);
   localparam int ACC_W = INPUT_BITS + 8;
   typedef enum logic {IDLE, ACCUM} state_t;
   state_t state, state_nx;
   logic strobe_d, accept, done;
   logic [2:0] k_q, k_in, k_use;
   logic [ACC_W-1:0] acc, acc_sum;
   logic [8:0] cnt;
   assign accept = data_valid_in & ~strobe_d;
   assign k_in = osr_mode_in > 3'd4 ? 3'd0 : osr_mode_in;
   assign k_use = state == IDLE ? k_in : k_q;
   assign acc_sum = acc + ACC_W'(data_in);
   assign done = accept & (state == IDLE ? k_in == 3'd0 : cnt + 9'd1 == 9'd1 << {k_q, 1'b0});
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   // next state: a completed window or a clear always returns to IDLE
   always_comb begin
      state_nx = state;
      if (clear_in) state_nx = IDLE;
      else if (accept) state_nx = done ? IDLE : ACCUM;
   end
   // output decode
   always_comb busy_out = state == ACCUM;
   // edge detector so a strobe held high counts as one conversion
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) strobe_d <= 1'b0;
      else strobe_d <= data_valid_in;
   // window accumulator, sample counter and the ratio latched at window start
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         k_q <= '0;
      end else if (clear_in) begin
         acc <= '0;
         cnt <= '0;
      end else if (accept) begin
         acc <= done ? '0 : acc_sum;
         cnt <= done ? '0 : cnt + 9'd1;
         if (state == IDLE) k_q <= k_in;
      end
   // output register: average is acc>>k left-aligned by 4-k; overwriting an unread result flags overrun
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         result_out <= '0;
         result_valid_out <= 1'b0;
         overrun_out <= 1'b0;
      end else if (clear_in) begin
         result_out <= '0;
         result_valid_out <= 1'b0;
         overrun_out <= 1'b0;
      end else if (done) begin
         result_out <= OUTPUT_BITS'((acc_sum >> k_use) << (3'd4 - k_use));
         result_valid_out <= 1'b1;
         if (result_valid_out & ~result_ready_in) overrun_out <= 1'b1;
      end else if (result_ready_in) result_valid_out <= 1'b0;
endmodule

// File: tb/tb_adc_osr_decimator.sv
// tb_adc_osr_decimator: directed and randomized checks of the oversampling decimator against an arithmetic model
module tb_adc_osr_decimator;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [11:0] data_in = '0;
   logic data_valid_in = 1'b0;
   logic [2:0] osr_mode_in = '0;
   logic clear_in = 1'b0;
   logic result_ready_in = 1'b0;
   logic [15:0] result_out;
   logic result_valid_out, overrun_out, busy_out;
   int errors = 0;
   int checks = 0;

   adc_osr_decimator dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid_in(data_valid_in),
      .osr_mode_in(osr_mode_in), .clear_in(clear_in), .result_ready_in(result_ready_in),
      .result_out(result_out), .result_valid_out(result_valid_out),
      .overrun_out(overrun_out), .busy_out(busy_out)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] avg_of(input int sum, input int k);
      return 16'((sum >> k) << (4 - k));
   endfunction

   function automatic int eff_k(input int mode);
      return mode > 4 ? 0 : mode;
   endfunction

   // drive a strobe for hold cycles; returns at the negedge after the accepting edge
   task automatic send(input logic [11:0] d, input int hold);
      @(negedge clk);
      data_in = d;
      data_valid_in = 1'b1;
      repeat (hold) @(negedge clk);
      data_valid_in = 1'b0;
   endtask

   task automatic consume(input string name);
      result_ready_in = 1'b1;
      @(negedge clk);
      result_ready_in = 1'b0;
      checks++;
      if (result_valid_out !== 1'b0) begin errors++; $display("FAIL %s consume: valid=%b expected 0", name, result_valid_out); end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if (result_out !== 16'h0) begin errors++; $display("FAIL reset result: got %h expected 0000", result_out); end
      checks++;
      if (result_valid_out !== 1'b0) begin errors++; $display("FAIL reset valid: got %b expected 0", result_valid_out); end
      checks++;
      if (overrun_out !== 1'b0) begin errors++; $display("FAIL reset overrun: got %b expected 0", overrun_out); end
      checks++;
      if (busy_out !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy_out); end
      rst_n = 1'b1;
   endtask

   task automatic test_mode0;
      osr_mode_in = 3'd0;
      send(12'hABC, 1);
      checks++;
      if (result_out !== 16'hABC0) begin errors++; $display("FAIL mode0 result: got %h expected abc0", result_out); end
      checks++;
      if (result_valid_out !== 1'b1) begin errors++; $display("FAIL mode0 valid: got %b expected 1", result_valid_out); end
      checks++;
      if (busy_out !== 1'b0) begin errors++; $display("FAIL mode0 busy: got %b expected 0", busy_out); end
      consume("mode0");
   endtask

   task automatic test_mode1;
      osr_mode_in = 3'd1;
      for (int i = 0; i < 4; i++) begin
         send(12'(100 + i), 1);
         if (i < 3) begin
            checks++;
            if (busy_out !== 1'b1) begin errors++; $display("FAIL mode1 busy sample %0d: got %b expected 1", i, busy_out); end
         end
      end
      checks++;
      if (result_out !== avg_of(406, 1)) begin errors++; $display("FAIL mode1 result: got %h expected %h", result_out, avg_of(406, 1)); end
      checks++;
      if (result_valid_out !== 1'b1 || busy_out !== 1'b0) begin errors++; $display("FAIL mode1 end: valid=%b busy=%b expected 1 0", result_valid_out, busy_out); end
      consume("mode1");
   endtask

   task automatic test_mode4;
      osr_mode_in = 3'd4;
      for (int i = 0; i < 256; i++) begin
         send(12'hFFF, 1);
         if (i == 254) begin
            checks++;
            if (busy_out !== 1'b1 || result_valid_out !== 1'b0) begin errors++; $display("FAIL mode4 mid: busy=%b valid=%b expected 1 0", busy_out, result_valid_out); end
         end
      end
      checks++;
      if (result_out !== 16'hFFF0) begin errors++; $display("FAIL mode4 result: got %h expected fff0", result_out); end
      checks++;
      if (result_valid_out !== 1'b1 || busy_out !== 1'b0) begin errors++; $display("FAIL mode4 end: valid=%b busy=%b expected 1 0", result_valid_out, busy_out); end
      consume("mode4");
   endtask

   task automatic test_overrun;
      osr_mode_in = 3'd0;
      send(12'h001, 1);
      send(12'h002, 1);
      checks++;
      if (result_out !== 16'h0020) begin errors++; $display("FAIL overrun result: got %h expected 0020", result_out); end
      checks++;
      if (result_valid_out !== 1'b1 || overrun_out !== 1'b1) begin errors++; $display("FAIL overrun flags: valid=%b overrun=%b expected 1 1", result_valid_out, overrun_out); end
      clear_in = 1'b1;
      @(negedge clk);
      clear_in = 1'b0;
      checks++;
      if ({result_out, result_valid_out, overrun_out, busy_out} !== 19'h0) begin errors++; $display("FAIL clear: result=%h valid=%b overrun=%b busy=%b expected all 0", result_out, result_valid_out, overrun_out, busy_out); end
   endtask

   task automatic test_hold;
      osr_mode_in = 3'd1;
      send(12'd10, 3);
      osr_mode_in = 3'd3;
      send(12'd20, 1);
      send(12'd30, 1);
      checks++;
      if (busy_out !== 1'b1 || result_valid_out !== 1'b0) begin errors++; $display("FAIL hold mid: busy=%b valid=%b expected 1 0", busy_out, result_valid_out); end
      send(12'd40, 1);
      checks++;
      if (result_out !== avg_of(100, 1)) begin errors++; $display("FAIL hold result: got %h expected %h", result_out, avg_of(100, 1)); end
      checks++;
      if (result_valid_out !== 1'b1 || busy_out !== 1'b0) begin errors++; $display("FAIL hold end: valid=%b busy=%b expected 1 0", result_valid_out, busy_out); end
      osr_mode_in = 3'd0;
      consume("hold");
   endtask

   task automatic test_reset_mid;
      osr_mode_in = 3'd1;
      send(12'd5, 1);
      send(12'd6, 1);
      checks++;
      if (busy_out !== 1'b1) begin errors++; $display("FAIL rstmid busy: got %b expected 1", busy_out); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({result_out, result_valid_out, overrun_out, busy_out} !== 19'h0) begin errors++; $display("FAIL rstmid outputs: result=%h valid=%b overrun=%b busy=%b expected all 0", result_out, result_valid_out, overrun_out, busy_out); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) send(12'd8, 1);
      checks++;
      if (result_out !== 16'h0080 || result_valid_out !== 1'b1) begin errors++; $display("FAIL rstmid result: got %h valid=%b expected 0080 1", result_out, result_valid_out); end
      consume("rstmid");
   endtask

   task automatic test_back_to_back;
      osr_mode_in = 3'd0;
      send(12'h123, 1);
      checks++;
      if (result_out !== 16'h1230) begin errors++; $display("FAIL b2b first: got %h expected 1230", result_out); end
      result_ready_in = 1'b1;
      send(12'h456, 1);
      checks++;
      if (result_out !== 16'h4560 || result_valid_out !== 1'b1 || overrun_out !== 1'b0) begin errors++; $display("FAIL b2b second: result=%h valid=%b overrun=%b expected 4560 1 0", result_out, result_valid_out, overrun_out); end
      @(negedge clk);
      result_ready_in = 1'b0;
      checks++;
      if (result_valid_out !== 1'b0) begin errors++; $display("FAIL b2b drain: valid=%b expected 0", result_valid_out); end
   endtask

   task automatic test_random;
      for (int w = 0; w < 25; w++) begin
         int mode, k, n, sum;
         logic [11:0] d;
         mode = $urandom_range(0, 7);
         if (mode == 4 && $urandom_range(0, 3) != 0) mode = 2;
         k = eff_k(mode);
         n = 1 << (2 * k);
         sum = 0;
         osr_mode_in = 3'(mode);
         for (int i = 0; i < n; i++) begin
            d = 12'($urandom_range(0, 4095));
            sum += d;
            send(d, $urandom_range(1, 3));
            osr_mode_in = 3'($urandom_range(0, 7));
            if (i == 0 && n > 1) begin
               checks++;
               if (busy_out !== 1'b1) begin errors++; $display("FAIL rand w%0d busy: got %b expected 1", w, busy_out); end
            end
         end
         checks++;
         if (result_out !== avg_of(sum, k)) begin errors++; $display("FAIL rand w%0d mode%0d result: got %h expected %h", w, mode, result_out, avg_of(sum, k)); end
         checks++;
         if (result_valid_out !== 1'b1 || busy_out !== 1'b0 || overrun_out !== 1'b0) begin errors++; $display("FAIL rand w%0d flags: valid=%b busy=%b overrun=%b expected 1 0 0", w, result_valid_out, busy_out, overrun_out); end
         consume("rand");
      end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode1();
      test_mode4();
      test_overrun();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
